// File: rtl/datastream_frame_generator.sv
// Frame generator: emits a SYNC_WORD preamble, forwards len upstream payload words
// tagged with frame_o, then holds an idle gap before the next frame may start.
module datastream_frame_generator #(
  parameter int unsigned         DATASIZE   = 8,
  parameter int unsigned         WINDOWSIZE = 4,
  parameter logic [DATASIZE-1:0] SYNC_WORD  = 8'hA5,
  parameter int unsigned         LENSIZE    = 8,
  parameter int unsigned         GAPCYCLES  = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                start_i,
  input  logic [LENSIZE-1:0]  len_i,
  output logic                busy_o,
  input  logic [DATASIZE-1:0] data_i,
  input  logic                valid_i,
  output logic                ready_o,
  output logic [DATASIZE-1:0] data_o,
  output logic                valid_o,
  input  logic                ready_i,
  output logic                frame_o,
  output logic [15:0]         frame_cnt_o
);

  localparam int unsigned PW       = (WINDOWSIZE > 1) ? $clog2(WINDOWSIZE) : 1;
  localparam int unsigned GAP_LAST = (GAPCYCLES > 1) ? GAPCYCLES - 1 : 0;
  localparam int unsigned GW       = (GAPCYCLES > 1) ? $clog2(GAPCYCLES) : 1;

  typedef enum logic [1:0] {S_IDLE, S_PREAMBLE, S_PAYLOAD, S_GAP} state_t;

  state_t              state_q, state_d;
  logic [LENSIZE-1:0]  len_q, len_d;
  logic [LENSIZE-1:0]  pay_cnt_q, pay_cnt_d;
  logic [PW-1:0]       pre_cnt_q, pre_cnt_d;
  logic [GW-1:0]       gap_cnt_q, gap_cnt_d;
  logic                busy_q, busy_d;
  logic [15:0]         frame_cnt_q, frame_cnt_d;
  logic [DATASIZE-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                frame_q, frame_d;

  logic                stage_free;
  logic                load;
  logic [DATASIZE-1:0] load_data;
  logic                load_frame;

  assign stage_free = !valid_q || ready_i;
  assign ready_o    = (state_q == S_PAYLOAD) && stage_free;

  always_comb begin
    state_d     = state_q;
    len_d       = len_q;
    pay_cnt_d   = pay_cnt_q;
    pre_cnt_d   = pre_cnt_q;
    gap_cnt_d   = gap_cnt_q;
    busy_d      = busy_q;
    frame_cnt_d = frame_cnt_q;
    load        = 1'b0;
    load_data   = data_q;
    load_frame  = frame_q;

    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          len_d     = len_i;
          busy_d    = 1'b1;
          pre_cnt_d = '0;
          pay_cnt_d = '0;
          gap_cnt_d = '0;
          state_d   = S_PREAMBLE;
        end
      end
      S_PREAMBLE: begin
        if (stage_free) begin
          load       = 1'b1;
          load_data  = SYNC_WORD;
          load_frame = 1'b0;
          pre_cnt_d  = pre_cnt_q + PW'(1);
          if (pre_cnt_q == PW'(WINDOWSIZE - 1))
            state_d = (len_q == '0) ? S_GAP : S_PAYLOAD;
        end
      end
      S_PAYLOAD: begin
        if (ready_o && valid_i) begin
          load       = 1'b1;
          load_data  = data_i;
          load_frame = 1'b1;
          pay_cnt_d  = pay_cnt_q + LENSIZE'(1);
          if (pay_cnt_q == len_q - LENSIZE'(1))
            state_d = S_GAP;
        end
      end
      S_GAP: begin
        // Gap cycles are only counted once the final word has left the output stage.
        if (!valid_q) begin
          if (gap_cnt_q == GW'(GAP_LAST)) begin
            state_d     = S_IDLE;
            busy_d      = 1'b0;
            frame_cnt_d = frame_cnt_q + 16'd1;
          end else begin
            gap_cnt_d = gap_cnt_q + GW'(1);
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    valid_d = load ? 1'b1 : (valid_q && !ready_i);
    data_d  = load ? load_data : data_q;
    frame_d = load ? load_frame : frame_q;
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q     <= S_IDLE;
      len_q       <= '0;
      pay_cnt_q   <= '0;
      pre_cnt_q   <= '0;
      gap_cnt_q   <= '0;
      busy_q      <= 1'b0;
      frame_cnt_q <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      frame_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      len_q       <= len_d;
      pay_cnt_q   <= pay_cnt_d;
      pre_cnt_q   <= pre_cnt_d;
      gap_cnt_q   <= gap_cnt_d;
      busy_q      <= busy_d;
      frame_cnt_q <= frame_cnt_d;
      data_q      <= data_d;
      valid_q     <= valid_d;
      frame_q     <= frame_d;
    end
  end

  assign busy_o      = busy_q;
  assign frame_cnt_o = frame_cnt_q;
  assign data_o      = data_q;
  assign valid_o     = valid_q;
  assign frame_o     = frame_q;

endmodule

// File: tb/tb_datastream_frame_generator.sv
// Scoreboard bench for datastream_frame_generator: each requested frame pushes its
// expected word list; a monitor pops and compares every downstream transfer.
module tb_datastream_frame_generator;

  localparam int unsigned DW   = 8;
  localparam int unsigned WS   = 4;
  localparam int unsigned LW   = 8;
  localparam int unsigned G    = 2;
  localparam logic [7:0]  SYNC = 8'hA5;
  localparam int unsigned GAP_EXP = (G == 0) ? 1 : G;

  logic          clk = 1'b0;
  logic          rst_i = 1'b0;
  logic          start_i = 1'b0;
  logic [LW-1:0] len_i = '0;
  logic          busy_o;
  logic [DW-1:0] data_i = '0;
  logic          valid_i = 1'b0;
  logic          ready_o;
  logic [DW-1:0] data_o;
  logic          valid_o;
  logic          ready_i = 1'b1;
  logic          frame_o;
  logic [15:0]   frame_cnt_o;

  datastream_frame_generator #(
    .DATASIZE(DW), .WINDOWSIZE(WS), .SYNC_WORD(SYNC), .LENSIZE(LW), .GAPCYCLES(G)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .start_i(start_i), .len_i(len_i), .busy_o(busy_o),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .data_o(data_o), .valid_o(valid_o), .ready_i(ready_i), .frame_o(frame_o),
    .frame_cnt_o(frame_cnt_o)
  );

  always #5 clk = ~clk;

  typedef struct packed { logic [7:0] d; logic f; } word_t;

  int unsigned n_checks = 0, n_pass = 0;
  word_t       exp_q[$];
  logic [7:0]  src_q[$];
  int unsigned cyc = 0, xfer_edge = 0;
  int unsigned up_cnt = 0, up_exp = 0, frames_exp = 0;
  int unsigned rdy_pct = 100, vld_pct = 100;
  logic [15:0] last_cnt = '0;
  logic        stalled = 1'b0, up_fire = 1'b0;
  word_t       held;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
  endtask

  task automatic fail(input string name);
    n_checks++;
    $display("FAIL %s (cycle %0d)", name, cyc);
  endtask

  always @(posedge clk) cyc++;

  // Downstream sink with random backpressure.
  always @(posedge clk) begin
    #1;
    ready_i = ($urandom_range(99) < rdy_pct);
  end

  // Upstream source: offers queued payload; once empty it offers stray words nobody may take.
  always @(posedge clk) begin
    if (up_fire && src_q.size() > 0) void'(src_q.pop_front());
    #1;
    if (src_q.size() > 0) begin
      valid_i = ($urandom_range(99) < vld_pct);
      data_i  = src_q[0];
    end else begin
      valid_i = $urandom_range(1);
      data_i  = 8'($urandom);
    end
  end

  // Monitor: all handshakes are judged at the negative edge, before the edge that completes them.
  always @(negedge clk) begin
    word_t e;
    up_fire = rst_i && valid_i && ready_o;
    if (up_fire) up_cnt++;
    if (rst_i) begin
      if (stalled) begin
        chk("hold_valid", valid_o, 1);
        chk("hold_word", {data_o, frame_o}, held);
      end
      if (valid_o && !ready_i) chk("ready_o_stalled", ready_o, 0);
      stalled = valid_o && !ready_i;
      held    = {data_o, frame_o};
      if (valid_o && ready_i) begin
        if (exp_q.size() == 0) fail("unexpected_word");
        else begin
          e = exp_q.pop_front();
          chk("word", {data_o, frame_o}, e);
          xfer_edge = cyc + 1;
        end
      end
      if (frame_cnt_o != last_cnt) begin
        chk("gap_len", cyc - xfer_edge, GAP_EXP);
        last_cnt = frame_cnt_o;
      end
    end
  end

  task automatic push_frame(input int unsigned len);
    logic [7:0] w;
    for (int unsigned i = 0; i < WS; i++) exp_q.push_back({SYNC, 1'b0});
    for (int unsigned i = 0; i < len; i++) begin
      w = ($urandom_range(3) == 0) ? SYNC : 8'($urandom);
      src_q.push_back(w);
      exp_q.push_back({w, 1'b1});
    end
    up_exp += len;
  endtask

  task automatic wait_frames(input int unsigned target, input int unsigned budget);
    int unsigned t = 0;
    while (frame_cnt_o != 16'(target) && t < budget) begin
      @(negedge clk);
      t++;
    end
    if (t >= budget) fail("timeout_frame_end");
  endtask

  task automatic end_checks();
    chk("frame_cnt", frame_cnt_o, 16'(frames_exp));
    chk("busy_end", busy_o, 0);
    chk("upstream_count", up_cnt, up_exp);
    chk("scoreboard_empty", exp_q.size(), 0);
  endtask

  task automatic run_frame(input int unsigned len);
    int unsigned t = 0;
    while (busy_o && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) fail("timeout_idle");
    push_frame(len);
    @(posedge clk); #1 start_i = 1'b1; len_i = LW'(len);
    @(posedge clk); #1 start_i = 1'b0;
    @(negedge clk);
    chk("busy_after_start", busy_o, 1);
    chk("latency_first_cycle", valid_o, 0);
    @(negedge clk);
    chk("latency_preamble", valid_o, 1);
    frames_exp++;
    wait_frames(frames_exp, 4000);
    end_checks();
  endtask

  initial begin
    #3;
    chk("rst_valid", valid_o, 0);
    chk("rst_data", data_o, 0);
    chk("rst_frame", frame_o, 0);
    chk("rst_ready", ready_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_cnt", frame_cnt_o, 0);
    repeat (2) @(negedge clk);
    rst_i = 1'b1;

    // basic, backpressure, bubbles, mixed, edge lengths
    run_frame(3);
    rdy_pct = 55;  run_frame(6); run_frame(3);
    rdy_pct = 100; vld_pct = 40; run_frame(3); run_frame(5);
    rdy_pct = 50;  vld_pct = 50;
    for (int i = 0; i < 4; i++) run_frame($urandom_range(20));
    rdy_pct = 100; vld_pct = 100; run_frame(0);
    rdy_pct = 70;  run_frame(0);
    rdy_pct = 100; run_frame(255);
    rdy_pct = 75;  vld_pct = 80; run_frame(255);

    // start held high: exactly one frame per return to IDLE
    rdy_pct = 100; vld_pct = 70;
    for (int i = 0; i < 3; i++) push_frame(2);
    @(posedge clk); #1 start_i = 1'b1; len_i = LW'(2);
    frames_exp += 3;
    wait_frames(frames_exp, 1000);
    start_i = 1'b0;
    repeat (10) @(negedge clk);
    end_checks();

    // reset in the middle of the payload
    vld_pct = 100;
    push_frame(5);
    @(posedge clk); #1 start_i = 1'b1; len_i = LW'(5);
    @(posedge clk); #1 start_i = 1'b0;
    begin
      int unsigned t = 0;
      while (exp_q.size() > 3 && t < 200) begin
        @(negedge clk);
        t++;
      end
      if (t >= 200) fail("timeout_mid_payload");
    end
    @(posedge clk); #2 rst_i = 1'b0;
    #1;
    chk("midrst_valid", valid_o, 0);
    chk("midrst_ready", ready_o, 0);
    chk("midrst_busy", busy_o, 0);
    chk("midrst_cnt", frame_cnt_o, 0);
    exp_q.delete();
    src_q.delete();
    up_cnt = 0; up_exp = 0; frames_exp = 0;
    last_cnt = '0; stalled = 1'b0; up_fire = 1'b0;
    repeat (2) @(negedge clk);
    rst_i = 1'b1;
    run_frame(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
